// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS sequencer that drives every datapath select/strobe.
// Latency: state registered; all outputs combinational from state, opcode, zero, alu_sign, mem_ready.
// Backpressure: mem_ready=0 holds FETCH / MEM_READ / MEM_WRITE one extra cycle per low cycle.
//
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   opcode                 instr[31:26] from the instruction register
//   zero, alu_sign         ALU zero flag and result bit 31 (branch resolution)
//   mem_ready              memory access completes this cycle
//   pc_write .. pc_source  datapath selects and strobes
//   instr_done             one-cycle pulse in the final cycle of each instruction
//   illegal                trap indicator (sticky until reset)
//   state                  current state, debug
//   cycle_count/instr_count  perf counters, built only with MC_PERF_COUNT_EN defined,
//                          otherwise tied to zero
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               alu_sign,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count
);

  typedef enum logic [STATE_W-1:0] {
    FETCH     = STATE_W'(0),
    DECODE    = STATE_W'(1),
    MEM_ADDR  = STATE_W'(2),
    MEM_READ  = STATE_W'(3),
    MEM_WB    = STATE_W'(4),
    MEM_WRITE = STATE_W'(5),
    R_EXEC    = STATE_W'(6),
    R_WB      = STATE_W'(7),
    BRANCH    = STATE_W'(8),
    JUMP      = STATE_W'(9),
    ADDI_EXEC = STATE_W'(10),
    ADDI_WB   = STATE_W'(11),
    TRAP      = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        // Branch target (PC+4 + imm<<2) is precomputed here for BRANCH.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:        state_d = R_EXEC;
          OP_J:            state_d = JUMP;
          OP_BEQ, OP_BGTZ: state_d = BRANCH;
          OP_ADDI:         state_d = ADDI_EXEC;
          OP_LW, OP_SW:    state_d = MEM_ADDR;
          default:         state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        // Write strobe only in the completing cycle so a stall never double-writes.
        iord = 1'b1;
        if (mem_ready) begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        instr_done = 1'b1;
        // bgtz compares rs against $0: taken when rs-0 is nonzero and non-negative.
        if (opcode == OP_BEQ)       pc_write = zero;
        else if (opcode == OP_BGTZ) pc_write = ~zero & ~alu_sign;
        state_d = FETCH;
      end
      JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;  // unused codes recover
    endcase

    // No strobe may escape while reset is held, whatever the state register says.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (instr_done) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed test-plan steps followed by randomized
// instructions. Expected state route, control word, cycles-per-instruction and
// counters come from an instruction-level model kept here.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero, alu_sign, mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write;
  logic        mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .alu_sign(alu_sign),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
    .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

`ifdef MC_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write;
    logic       mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal;
  } ctl_t;

  int          checks = 0;
  int          errors = 0;
  int          mstate;
  int unsigned mcyc, mins;
  logic [5:0]  cur_op;
  logic        cur_z, cur_s;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control word each state should present, straight from the per-state rules.
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic z,
                                   input logic s, input logic mr, input logic rn);
    ctl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      5:  begin c.iord = 1; c.mem_write = mr; c.instr_done = mr; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      8:  begin
            c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.instr_done = 1;
            c.pc_write = (op == 6'd4) ? z : ((op == 6'd7) ? (!z && !s) : 1'b0);
          end
      9:  begin c.pc_source = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; c.instr_done = 1; end
      12: c.illegal = 1;
      default: c = '0;
    endcase
    if (!rn) begin
      c.pc_write = 0; c.ir_write = 0; c.reg_write = 0; c.mem_read = 0;
      c.mem_write = 0; c.instr_done = 0; c.illegal = 0;
    end
    return c;
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'd35:       return 5;
      6'd43:       return 4;
      6'd0, 6'd8:  return 4;
      default:     return 3;
    endcase
  endfunction

  // One clock: drive inputs at the falling edge, check, then let the rising edge happen.
  task automatic drive_and_check(input logic mr, input logic rn);
    ctl_t e, obs;
    @(negedge clk);
    rst_n = rn; mem_ready = mr; opcode = cur_op; zero = cur_z; alu_sign = cur_s;
    #1;
    e   = exp_ctl(mstate, cur_op, cur_z, cur_s, mr, rn);
    obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal};
    check_val("state", 32'(state), 32'(mstate));
    check_val("ctl", 32'(obs), 32'(e));
    check_val("cycle_count", cycle_count, PERF ? mcyc : 32'd0);
    check_val("instr_count", instr_count, PERF ? mins : 32'd0);
    if (rn) begin
      mcyc++;
      if (e.instr_done) mins++;
    end else begin
      mcyc = 0;
      mins = 0;
    end
  endtask

  // Walk one instruction along its route. Wait states (FETCH, MEM_READ, MEM_WRITE)
  // repeat while mem_ready is low. abort_idx >= 0 pulls reset at that route step.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s,
                           input int stall_pct, input int mem_stalls, input int abort_idx);
    int   route[$];
    int   n = 0, stalls = 0, left = mem_stalls;
    logic mr;
    cur_op = op; cur_z = z; cur_s = s;
    route = '{0, 1};
    case (op)
      6'd0:        begin route.push_back(6); route.push_back(7); end
      6'd2:        route.push_back(9);
      6'd4, 6'd7:  route.push_back(8);
      6'd8:        begin route.push_back(10); route.push_back(11); end
      6'd35:       begin route.push_back(2); route.push_back(3); route.push_back(4); end
      6'd43:       begin route.push_back(2); route.push_back(5); end
      default:     route.push_back(12);
    endcase
    for (int i = 0; i < route.size(); i++) begin
      int st = route[i];
      int waited = 0;
      mstate = st;
      if (i == abort_idx) begin
        drive_and_check(1'($urandom), 1'b0);
        mstate = 0;
        return;
      end
      if (st == 12) begin
        repeat (20) drive_and_check(1'($urandom), 1'b1);
        return;
      end
      do begin
        mr = 1'b1;
        if (st == 0 || st == 3 || st == 5) begin
          if (stall_pct > 0 && waited < 20) mr = ($urandom_range(0, 99) >= stall_pct);
          else if (st != 0 && left > 0) begin mr = 1'b0; left--; end
        end
        drive_and_check(mr, 1'b1);
        n++;
        if (!mr) begin stalls++; waited++; end
      end while (!mr);
    end
    check_val("cpi", 32'(n), 32'(base_cycles(op) + stalls));
    mstate = 0;
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) begin
      drive_and_check(1'($urandom), 1'b0);
      mstate = 0;
    end
  endtask

  // Idle FETCH cycle used to read the counters against fixed values.
  task automatic peek_counts(input int unsigned c, input int unsigned i);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    check_val("peek_state", 32'(state), 32'd0);
    check_val("peek_cycle_count", cycle_count, PERF ? c : 32'd0);
    check_val("peek_instr_count", instr_count, PERF ? i : 32'd0);
    mcyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] legal [7];
    legal = '{6'd0, 6'd2, 6'd4, 6'd7, 6'd8, 6'd35, 6'd43};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0; alu_sign = 1'b0;
    cur_op = 6'd0; cur_z = 1'b0; cur_s = 1'b0;
    repeat (2) @(posedge clk);
    mstate = 0; mcyc = 0; mins = 0;

    run_instr(6'd8, 0, 0, 0, 0, -1);            // addi: 0,1,10,11
    run_instr(6'd35, 0, 0, 0, 2, -1);           // lw, two stalls in MEM_READ -> 7 cycles
    run_instr(6'd4, 1, 0, 0, 0, -1);            // beq taken
    run_instr(6'd4, 0, 0, 0, 0, -1);            // beq not taken
    run_instr(6'd7, 0, 1, 0, 0, -1);            // bgtz negative
    run_instr(6'd7, 0, 0, 0, 0, -1);            // bgtz positive
    run_instr(6'd7, 1, 0, 0, 0, -1);            // bgtz zero
    run_instr(6'd43, 0, 0, 0, 1, -1);           // sw with one stall
    run_instr(6'd2, 0, 0, 0, 0, -1);            // j
    run_instr(6'd0, 0, 0, 0, 0, -1);            // R-type
    run_instr(6'd63, 0, 0, 0, 0, -1);           // illegal -> TRAP for 20 cycles
    do_reset(1);

    repeat (3) run_instr(6'd8, 0, 0, 0, 0, -1);
    peek_counts(12, 3);
    run_instr(6'd0, 0, 0, 0, 0, 2);             // reset during R_EXEC
    peek_counts(0, 0);

    repeat (40) run_instr(legal[$urandom_range(0, 6)], 1'($urandom), 1'($urandom), 30, 0, -1);
    run_instr(6'd13, 0, 0, 30, 0, -1);          // another illegal, under random fetch stalls
    do_reset(2);
    run_instr(6'd35, 0, 0, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
